// File: rtl/accum_bist_pkg.sv
// Shared definitions for the accumulator RAM March C- BIST.
// Holds the controller state encoding, the March element indices and the
// per-element lookup tables (address direction, read and write backgrounds).
// The result register of the BIST top-level uses the same definitions.
package accum_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } bist_state_e;

    localparam logic [2:0] E0 = 3'd0;  // up   (w0)
    localparam logic [2:0] E1 = 3'd1;  // up   (r0,w1)
    localparam logic [2:0] E2 = 3'd2;  // up   (r1,w0)
    localparam logic [2:0] E3 = 3'd3;  // down (r0,w1)
    localparam logic [2:0] E4 = 3'd4;  // down (r1,w0)
    localparam logic [2:0] E5 = 3'd5;  // up   (r0)

    // One bit per element, indexed by element number. The tables are 8 bits
    // wide so a 3-bit element index never reaches past the end.
    localparam logic [7:0] ELEM_DOWN  = 8'b0001_1000;  // 1: walk N-1..0
    localparam logic [7:0] ELEM_RD_BG = 8'b0001_0100;  // expected read value
    localparam logic [7:0] ELEM_WR_BG = 8'b0000_1010;  // value written

endpackage

// File: rtl/accum_ram_port_mux.sv
// RAM port selection between the functional datapath and the BIST engine.
// Ports:
//   busy_i                      - 1: BIST owns the RAM, functional writes dropped
//   func_{wr_en,wr_addr,din,rd_addr}_i - functional datapath request
//   bist_{wr_en,addr,din}_i     - BIST request (one address for both ports)
//   ram_{wr_en,wr_addr,din,rd_addr}_o  - to the RAM instance
module accum_ram_port_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  busy_i,
    input  logic                  func_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] func_wr_addr_i,
    input  logic [DATA_WIDTH-1:0] func_din_i,
    input  logic [ADDR_WIDTH-1:0] func_rd_addr_i,
    input  logic                  bist_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] bist_addr_i,
    input  logic [DATA_WIDTH-1:0] bist_din_i,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] ram_din_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o
);

    assign ram_wr_en_o   = busy_i ? bist_wr_en_i : func_wr_en_i;
    assign ram_wr_addr_o = busy_i ? bist_addr_i  : func_wr_addr_i;
    assign ram_din_o     = busy_i ? bist_din_i   : func_din_i;
    assign ram_rd_addr_o = busy_i ? bist_addr_i  : func_rd_addr_i;

endmodule

// File: rtl/accum_ram_bist_ctrl.sv
// March C- BIST sequencer for the accumulator scratch RAM (sync write port,
// async read port). Owns the RAM while busy, otherwise passes the functional
// datapath straight through.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   start                - begin a test (ignored unless idle)
//   busy, done           - test running / one-cycle completion pulse
//   pass, fail_addr, fail_elem, err_cnt - results of the last test
//   func_*               - functional RAM request
//   ram_*                - RAM interface
module accum_ram_bist_ctrl
    import accum_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ARRAY_SIZE = 16,
    parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE),
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    input  logic                  func_wr_en,
    input  logic [ADDR_WIDTH-1:0] func_wr_addr,
    input  logic [DATA_WIDTH-1:0] func_din,
    input  logic [ADDR_WIDTH-1:0] func_rd_addr,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ARRAY_SIZE - 1);

    bist_state_e           state_q;
    logic [2:0]            elem_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  busy_q, done_q, pass_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]            fail_elem_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic                  mismatch, elem_last;
    logic [2:0]            elem_nxt;
    logic [ADDR_WIDTH-1:0] addr_step, addr_first_nxt;
    logic [DATA_WIDTH-1:0] rd_bg, wr_bg;

    assign rd_bg = {DATA_WIDTH{ELEM_RD_BG[elem_q]}};
    assign wr_bg = {DATA_WIDTH{ELEM_WR_BG[elem_q]}};

    // Read data is async, so the compare happens in the RD cycle itself.
    assign mismatch  = (state_q == ST_RD) && (ram_dout != rd_bg);
    assign err_cnt_d = (mismatch && (err_cnt_q != '1)) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;

    // Stepping is explicit at both ends, so the counter stays in 0..N-1
    // even when N is not a power of two.
    assign elem_last      = ELEM_DOWN[elem_q] ? (addr_q == '0) : (addr_q == ADDR_LAST);
    assign elem_nxt       = elem_q + 3'd1;
    assign addr_first_nxt = ELEM_DOWN[elem_nxt] ? ADDR_LAST : '0;
    assign addr_step      = ELEM_DOWN[elem_q] ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= E0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_WR;
                        elem_q      <= E0;
                        addr_q      <= '0;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_elem_q <= '0;
                        err_cnt_q   <= '0;
                    end
                end
                ST_WR: begin
                    // E0 is write-only and stays in WR until its last address;
                    // every other write is followed by the next read.
                    if (elem_q != E0 || elem_last) state_q <= ST_RD;
                    if (elem_last) begin
                        elem_q <= elem_nxt;
                        addr_q <= addr_first_nxt;
                    end else begin
                        addr_q <= addr_step;
                    end
                end
                ST_RD: begin
                    err_cnt_q <= err_cnt_d;
                    // Saturating counter never returns to zero, so zero means
                    // this is the first mismatch of the run.
                    if (mismatch && (err_cnt_q == '0)) begin
                        fail_addr_q <= addr_q;
                        fail_elem_q <= elem_q;
                    end
                    if (elem_q != E5) begin
                        state_q <= ST_WR;
                    end else if (elem_last) begin
                        // busy drops and done rises together; pass includes
                        // a mismatch seen in this final read.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end else begin
                        addr_q <= addr_step;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign err_cnt   = err_cnt_q;

    accum_ram_port_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_port_mux (
        .busy_i        (busy_q),
        .func_wr_en_i  (func_wr_en),
        .func_wr_addr_i(func_wr_addr),
        .func_din_i    (func_din),
        .func_rd_addr_i(func_rd_addr),
        .bist_wr_en_i  (state_q == ST_WR),
        .bist_addr_i   (addr_q),
        .bist_din_i    (wr_bg),
        .ram_wr_en_o   (ram_wr_en),
        .ram_wr_addr_o (ram_wr_addr),
        .ram_din_o     (ram_din),
        .ram_rd_addr_o (ram_rd_addr)
    );

endmodule

// File: tb/tb_accum_ram_bist_ctrl.sv
module tb_accum_ram_bist_ctrl;

    localparam int DW = 32;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic          func_wr_en;
    logic [AW-1:0] func_wr_addr, func_rd_addr;
    logic [DW-1:0] func_din;

    // DUT 1: 8-bit error counter, model RAM with selectable faults
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [7:0]    err_cnt;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_din, ram_dout;

    // DUT 2: 2-bit error counter, every word stuck-at-0
    logic          busy2, done2, pass2;
    logic [AW-1:0] fail_addr2;
    logic [2:0]    fail_elem2;
    logic [1:0]    err_cnt2;
    logic          ram_wr_en2;
    logic [AW-1:0] ram_wr_addr2, ram_rd_addr2;
    logic [DW-1:0] ram_din2;
    logic [DW-1:0] ram_dout2;

    logic [DW-1:0] mem [N];
    int            fault_mode;
    int            n_chk = 0;
    int            n_fail = 0;
    int            done_cyc, busy_cyc, extra_done, extra_busy;

    always #5 clk = ~clk;

    accum_ram_bist_ctrl #(.DATA_WIDTH(DW), .ARRAY_SIZE(N), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .err_cnt(err_cnt),
        .func_wr_en(func_wr_en), .func_wr_addr(func_wr_addr),
        .func_din(func_din), .func_rd_addr(func_rd_addr),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_din(ram_din), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout)
    );

    accum_ram_bist_ctrl #(.DATA_WIDTH(DW), .ARRAY_SIZE(N), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy2), .done(done2), .pass(pass2),
        .fail_addr(fail_addr2), .fail_elem(fail_elem2), .err_cnt(err_cnt2),
        .func_wr_en(func_wr_en), .func_wr_addr(func_wr_addr),
        .func_din(func_din), .func_rd_addr(func_rd_addr),
        .ram_wr_en(ram_wr_en2), .ram_wr_addr(ram_wr_addr2),
        .ram_din(ram_din2), .ram_rd_addr(ram_rd_addr2), .ram_dout(ram_dout2)
    );

    assign ram_dout2 = '0;

    always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_din;

    // Faults applied on the read path: 1 = addr 5 bit 3 SA0, 2 = addr 9 bit 0 SA1
    always_comb begin
        ram_dout = mem[ram_rd_addr];
        if (fault_mode == 1 && ram_rd_addr == 4'd5) ram_dout[3] = 1'b0;
        if (fault_mode == 2 && ram_rd_addr == 4'd9) ram_dout[0] = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start held for 'hold' sampled edges; returns the cycle (after the first
    // sampling edge) in which done is seen, and how many cycles busy was high.
    task automatic run_test(input int hold, output int dcyc, output int bcyc);
        int cyc;
        start = 1'b1;
        tick();
        cyc  = 1;
        bcyc = 0;
        while (!done && cyc < 400) begin
            if (cyc == hold) start = 1'b0;
            if (cyc == 155) func_wr_en = 1'b0;
            if (busy) bcyc++;
            tick();
            cyc++;
        end
        start = 1'b0;
        dcyc  = cyc;
    endtask

    task automatic quiet(input int cycles, output int dn, output int bz);
        dn = 0;
        bz = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) dn++;
            if (busy) bz++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; fault_mode = 0;
        func_wr_en = 1'b0; func_wr_addr = '0; func_din = '0; func_rd_addr = '0;
        tick(); tick();
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_done",      64'(done), 64'd0);
        chk("rst_pass",      64'(pass), 64'd0);
        chk("rst_fail_addr", 64'(fail_addr), 64'd0);
        chk("rst_fail_elem", 64'(fail_elem), 64'd0);
        chk("rst_err_cnt",   64'(err_cnt), 64'd0);
        func_wr_en = 1'b1; func_wr_addr = 4'd6; func_din = 32'hA5A5_0F0F; func_rd_addr = 4'd11;
        #1;
        chk("rst_pt_wr_en",   64'(ram_wr_en), 64'd1);
        chk("rst_pt_wr_addr", 64'(ram_wr_addr), 64'd6);
        chk("rst_pt_din",     64'(ram_din), 64'hA5A5_0F0F);
        chk("rst_pt_rd_addr", 64'(ram_rd_addr), 64'd11);
        rst_n = 1'b1;
        tick();

        // Clean run; functional writes to addr 3 are held on during busy
        func_wr_en = 1'b1; func_wr_addr = 4'd3; func_din = 32'hDEAD_BEEF;
        run_test(1, done_cyc, busy_cyc);
        chk("clean_done_cyc", 64'(done_cyc), 64'd161);
        chk("clean_busy_cyc", 64'(busy_cyc), 64'd160);
        chk("clean_pass",     64'(pass), 64'd1);
        chk("clean_err_cnt",  64'(err_cnt), 64'd0);
        chk("clean_busy_in_done", 64'(busy), 64'd0);
        chk("clean_mem3",     64'(mem[3]), 64'd0);
        chk("sat_pass",       64'(pass2), 64'd0);
        chk("sat_err_cnt",    64'(err_cnt2), 64'd3);
        chk("sat_fail_addr",  64'(fail_addr2), 64'd0);
        chk("sat_fail_elem",  64'(fail_elem2), 64'd2);
        tick();
        chk("clean_done_pulse", 64'(done), 64'd0);
        chk("clean_pass_held",  64'(pass), 64'd1);

        // Addr 5 bit 3 stuck-at-0
        fault_mode = 1;
        run_test(1, done_cyc, busy_cyc);
        chk("sa0_done_cyc",  64'(done_cyc), 64'd161);
        chk("sa0_pass",      64'(pass), 64'd0);
        chk("sa0_fail_addr", 64'(fail_addr), 64'd5);
        chk("sa0_fail_elem", 64'(fail_elem), 64'd2);
        chk("sa0_err_cnt",   64'(err_cnt), 64'd2);
        tick();

        // Addr 9 bit 0 stuck-at-1 (last mismatch lands in the final E5 sweep)
        fault_mode = 2;
        run_test(1, done_cyc, busy_cyc);
        chk("sa1_pass",      64'(pass), 64'd0);
        chk("sa1_fail_addr", 64'(fail_addr), 64'd9);
        chk("sa1_fail_elem", 64'(fail_elem), 64'd1);
        chk("sa1_err_cnt",   64'(err_cnt), 64'd3);
        tick();

        // Reset at cycle 50 of a run
        fault_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        chk("mid_busy_before", 64'(busy), 64'd1);
        func_wr_en = 1'b1; func_wr_addr = 4'd7; func_din = 32'hCAFE_F00D; func_rd_addr = 4'd2;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy",    64'(busy), 64'd0);
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("mid_rst_wr_en",   64'(ram_wr_en), 64'd1);
        chk("mid_rst_wr_addr", 64'(ram_wr_addr), 64'd7);
        chk("mid_rst_din",     64'(ram_din), 64'hCAFE_F00D);
        chk("mid_rst_rd_addr", 64'(ram_rd_addr), 64'd2);
        rst_n = 1'b1;
        fault_mode = 0;
        func_wr_en = 1'b0;
        tick();
        run_test(1, done_cyc, busy_cyc);
        chk("post_rst_done_cyc", 64'(done_cyc), 64'd161);
        chk("post_rst_pass",     64'(pass), 64'd1);
        tick();

        // Start held for three cycles: one test only
        run_test(3, done_cyc, busy_cyc);
        chk("hold3_done_cyc", 64'(done_cyc), 64'd161);
        chk("hold3_pass",     64'(pass), 64'd1);
        // Start asserted in the DONE cycle is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_done_busy", 64'(busy), 64'd0);
        quiet(200, extra_done, extra_busy);
        chk("no_extra_done", 64'(extra_done), 64'd0);
        chk("no_extra_busy", 64'(extra_busy), 64'd0);

        // Idle passthrough
        func_wr_en = 1'b0; func_wr_addr = 4'hA; func_din = 32'h1234_5678; func_rd_addr = 4'h5;
        #1;
        chk("pt_a_wr_en",   64'(ram_wr_en), 64'd0);
        chk("pt_a_wr_addr", 64'(ram_wr_addr), 64'hA);
        chk("pt_a_din",     64'(ram_din), 64'h1234_5678);
        chk("pt_a_rd_addr", 64'(ram_rd_addr), 64'h5);
        func_wr_en = 1'b1; func_wr_addr = 4'hF; func_din = 32'h8000_0001; func_rd_addr = 4'h0;
        #1;
        chk("pt_b_wr_en",   64'(ram_wr_en), 64'd1);
        chk("pt_b_wr_addr", 64'(ram_wr_addr), 64'hF);
        chk("pt_b_din",     64'(ram_din), 64'h8000_0001);
        chk("pt_b_rd_addr", 64'(ram_rd_addr), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_ram_bist_ctrl.md
Name: accum_ram_bist_ctrl

Overview:
- Sequencing controller for the accumulator scratch RAM: one write port (synchronous) and one read port (asynchronous, combinational read data).
- Runs a March C- test over every RAM word and reports pass/fail, the first failing address and March element, and a saturating error count.
- When idle, the functional datapath's write/read-address signals pass through to the RAM. While a test runs, the controller owns the RAM.
- Sits between the accumulator datapath and the RAM instance. The BIST top-level starts it and reads its results.

Parameters:
- DATA_WIDTH, 32, RAM word width
- ARRAY_SIZE, 16, number of RAM words (N), >=2
- ADDR_WIDTH, $clog2(ARRAY_SIZE), RAM address width
- ERR_CNT_W, 8, width of saturating error counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request to begin a test; ignored while busy
- busy  out  1  test in progress, controller owns the RAM
- done  out  1  one-cycle pulse when a test completes
- pass  out  1  result of last test, held until next start
- fail_addr  out  ADDR_WIDTH  address of first mismatch
- fail_elem  out  3  March element (0-5) of first mismatch
- err_cnt  out  ERR_CNT_W  total mismatches, saturates at all-ones
- func_wr_en  in  1  functional write enable
- func_wr_addr  in  ADDR_WIDTH  functional write address
- func_din  in  DATA_WIDTH  functional write data
- func_rd_addr  in  ADDR_WIDTH  functional read address
- ram_wr_en  out  1  to RAM write enable
- ram_wr_addr  out  ADDR_WIDTH  to RAM write address
- ram_din  out  DATA_WIDTH  to RAM write data
- ram_rd_addr  out  ADDR_WIDTH  to RAM read address
- ram_dout  in  DATA_WIDTH  from RAM async read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - busy=0, done=0, pass=0, fail_addr=0, fail_elem=0, err_cnt=0.
  - State=IDLE, address counter=0.
  - RAM-side outputs follow the func_* inputs.
- RAM port mux (combinational, selected by registered state):
  - busy=0: ram_* = func_* (ram_wr_en=func_wr_en).
  - busy=1: func_* are ignored and functional writes are dropped; BIST drives ram_*.
- March C- sequence. Background D0 is all-zeros, D1 is all-ones.
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
  - ⇑ = address 0..N-1; ⇓ = N-1..0.
- States: IDLE, WR, RD, DONE. A registered element index (0-5) and address counter accompany the state.
- IDLE:
  - start=1 -> WR, elem=0, addr=0, busy<=1.
  - pass, fail_addr, fail_elem and err_cnt are cleared on this same edge.
- RD (one cycle per address):
  - ram_rd_addr=addr, ram_wr_en=0.
  - ram_dout is compared combinationally against the expected background in the same cycle.
  - Mismatch -> err_cnt+1 (saturating). On the first mismatch of the run, latch fail_addr and fail_elem.
  - Next state: WR (E1-E4), or address step / advance (E5).
- WR (one cycle):
  - ram_wr_en=1, ram_wr_addr=addr, ram_din=background.
  - E0 steps the address directly.
  - E1-E4 step the address and return to RD.
- Address step:
  - At the last address of an element (N-1 for ⇑, 0 for ⇓), advance elem.
  - Load the start address for the new element: 0 for E1, E2, E5; N-1 for E3, E4.
  - After E5 at the last address -> DONE.
- Cycle count: total test length is 10N cycles (E0 N, E1-E4 2N each, E5 N).
- DONE (one cycle): done=1, busy<=0, pass<=(err_cnt==0 including any final-cycle error). Then -> IDLE.
- Timing relative to start:
  - busy rises on the edge sampling start.
  - The first BIST write is in the cycle immediately after that edge.
  - done pulses in cycle 10N+1 after start is sampled.
- Read-after-write: a write lands at the posedge, and the following RD cycle observes it. No extra wait states.
- start while busy or in DONE: ignored.
- Reset mid-test: on the next edge, busy=0 and the RAM mux returns to functional. Results are cleared. RAM contents are undefined.
- Wrap-around: the address counter never leaves 0..N-1, including for non-power-of-2 N.

Decomposition:
- Shared package accum_bist_pkg contains:
  - state enum
  - element-index constants E0-E5
  - per-element direction bit, read-background and write-background lookup constants
- Package entries are reused by the future top-level BIST result register.
- Sub-module accum_ram_port_mux: the pure combinational func/BIST selection. Everything else stays in one module.

Test Plan:
- Clean model RAM, N=16, start pulse -> busy for 160 cycles, done pulse at cycle 161, pass=1, err_cnt=0. Functional writes issued during busy leave RAM unchanged.
- Model RAM with addr 5 bit 3 stuck-at-0 -> pass=0, fail_addr=5, fail_elem=2, err_cnt=2 (E2, E4 reads).
- Addr 9 bit 0 stuck-at-1 -> fail_addr=9, fail_elem=1, err_cnt=3 (E1, E3, E5).
- Every word stuck-at-0 with ERR_CNT_W=2 -> err_cnt saturates at 3, fail_addr=0, fail_elem=2.
- rst_n low at cycle 50 of a run -> next edge busy=0, ram_* follow func_*. A new start then gives done at cycle 161 with pass=1.
- start held high for 3 cycles, and start asserted in the DONE cycle -> exactly one test per accepted start. Idle passthrough matches func_* bit-exactly.
